// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs
// Multi-cycle datapath that sits between the multi-cycle control unit and a
// unified instruction/data memory. PC, IR, MDR, ALUOut and the output port are
// registered here. Memory is reached through a small IDLE -> REQ -> DONE
// handshake FSM, so memory latency is variable. The control unit waits on
// mem_done before it moves on.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   reg_write, reg_dst    RF write enable and write-address select
//   mem_to_reg            RF write-data select (ALUOut / MDR / PC+1)
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation code
//   pc_source, pc_write   PC next-value select and load enable
//   mem_start, mem_we,    start one memory access; the access type, address
//   iord, mem_fetch       source and fetch flag are sampled with mem_start
//   out_write             load output_port from RF[rs]
//   mem_req, mem_wr,      memory request, write strobe, address and write
//   mem_addr, mem_wdata   data; all are held stable until acknowledged
//   mem_rdata, mem_ack    memory read data and acknowledge
//   mem_busy, mem_done    memory FSM is busy / one-cycle completion pulse
//   ir_out                IR[15:0] for opcode and function decode
//   alu_compare           signed compare of ALU operands (00 eq, 01 lt, 10 gt)
//   output_port,          registered output value and its one-cycle strobe
//   output_valid
module mc_datapath_hs #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reg_write,
  input  logic [1:0]           reg_dst,
  input  logic [1:0]           mem_to_reg,
  input  logic                 alu_src_a,
  input  logic [1:0]           alu_src_b,
  input  logic [3:0]           alu_op,
  input  logic [1:0]           pc_source,
  input  logic                 pc_write,
  input  logic                 mem_start,
  input  logic                 mem_we,
  input  logic                 iord,
  input  logic                 mem_fetch,
  input  logic                 out_write,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_busy,
  output logic                 mem_done,
  output logic [15:0]          ir_out,
  output logic [1:0]           alu_compare,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 output_valid
);

  localparam int W = WORD_SIZE;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t;

  mem_state_t     state_q, state_d;
  logic [W-1:0]   pc, mdr, alu_out;
  logic [W-1:0]   rf [4];
  logic [15:0]    ir;
  logic [1:0]     rs, rt, rd;
  logic [W-1:0]   alu_a, alu_b, alu_result, imm_sext, pc_plus1, pc_next;
  logic [W-1:0]   rf_wdata;
  logic [1:0]     rf_waddr;
  logic [W-1:0]   addr_q, wdata_q;
  logic           wr_q, fetch_q;

  assign rs       = ir[11:10];
  assign rt       = ir[9:8];
  assign rd       = ir[7:6];
  assign imm_sext = {{(W-8){ir[7]}}, ir[7:0]};
  assign pc_plus1 = pc + 1'b1;

  // Operand selection and ALU; undefined op codes produce zero.
  always_comb begin
    alu_a = alu_src_a ? rf[rs] : pc;
    case (alu_src_b)
      2'd0:    alu_b = rf[rt];
      2'd1:    alu_b = W'(1);
      2'd2:    alu_b = imm_sext;
      default: alu_b = '0;
    endcase
    alu_result = '0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = ~alu_a;
      4'd5: alu_result = '0 - alu_a;
      4'd6: alu_result = {alu_a[W-2:0], 1'b0};
      4'd7: alu_result = {alu_a[W-1], alu_a[W-1:1]};
      4'd8: alu_result[15:0] = {alu_b[7:0], 8'h00};
      default: alu_result = '0;
    endcase
  end

  // Signed compare of the raw ALU operands for branch decisions.
  always_comb begin
    alu_compare = 2'b00;
    if ($signed(alu_a) < $signed(alu_b))
      alu_compare = 2'b01;
    else if ($signed(alu_a) > $signed(alu_b))
      alu_compare = 2'b10;
  end

  // Register-file write port and PC next-value muxes.
  always_comb begin
    case (mem_to_reg)
      2'd1:    rf_wdata = mdr;
      2'd2:    rf_wdata = pc_plus1;
      default: rf_wdata = alu_out;
    endcase
    case (reg_dst)
      2'd1:    rf_waddr = rd;
      2'd2:    rf_waddr = 2'd2;
      default: rf_waddr = rt;
    endcase
    case (pc_source)
      2'd0:    pc_next = alu_result;
      2'd1:    pc_next = alu_out;
      2'd2:    pc_next = rf[rs];
      default: pc_next = {pc[W-1:12], ir[11:0]};
    endcase
  end

  // Architectural registers: PC, ALUOut, RF and the output port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= PC_RESET;
      alu_out      <= '0;
      output_port  <= '0;
      output_valid <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      alu_out      <= alu_result;
      output_valid <= out_write;
      if (pc_write)  pc <= pc_next;
      if (reg_write) rf[rf_waddr] <= rf_wdata;
      if (out_write) output_port <= rf[rs];
    end
  end

  // Memory FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MEM_IDLE;
    else          state_q <= state_d;
  end

  // Memory FSM next state; mem_start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (mem_start) state_d = MEM_REQ;
      MEM_REQ:  if (mem_ack)   state_d = MEM_DONE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Access attributes are captured at the start so they stay frozen during REQ;
  // IR and MDR only change on an acknowledged read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
      mdr     <= '0;
      ir      <= '0;
    end else begin
      if (state_q == MEM_IDLE && mem_start) begin
        addr_q  <= iord ? alu_out : pc;
        wdata_q <= rf[rt];
        wr_q    <= mem_we;
        fetch_q <= mem_fetch;
      end
      if (state_q == MEM_REQ && mem_ack && !wr_q) begin
        mdr <= mem_rdata;
        if (fetch_q) ir <= mem_rdata[15:0];
      end
    end
  end

  assign mem_req   = (state_q == MEM_REQ);
  assign mem_wr    = wr_q & mem_req;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_busy  = (state_q != MEM_IDLE);
  assign mem_done  = (state_q == MEM_DONE);
  assign ir_out    = ir;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// tb_mc_datapath_hs
// Self-checking bench for mc_datapath_hs (16-bit, PC reset 0x0010). A
// behavioural model of the architectural registers is advanced once per clock
// edge; memory accesses are sequenced as whole transactions by the bench.
module tb_mc_datapath_hs;

  localparam logic [15:0] PC_INIT = 16'h0010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_write, alu_src_a, pc_write, mem_start, mem_we, iord, mem_fetch, out_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [3:0]  alu_op;
  logic        mem_req, mem_wr, mem_ack, mem_busy, mem_done, output_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, ir_out, output_port;
  logic [1:0]  alu_compare;

  always #5 clk = ~clk;

  mc_datapath_hs #(.WORD_SIZE(16), .PC_RESET(PC_INIT)) dut (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .pc_write(pc_write),
    .mem_start(mem_start), .mem_we(mem_we), .iord(iord), .mem_fetch(mem_fetch),
    .out_write(out_write), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .mem_done(mem_done), .ir_out(ir_out),
    .alu_compare(alu_compare), .output_port(output_port), .output_valid(output_valid)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [15:0] m_pc, m_ir, m_mdr, m_alu_out, m_out;
  logic [15:0] m_rf [4];
  logic        m_out_valid;

  // Values seen on the bus in the first REQ cycle of the latest access
  logic [15:0] obs_addr, obs_wdata;
  logic        obs_wr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ~a;
      4'd5: return 16'd0 - a;
      4'd6: return a * 16'd2;
      4'd7: return (a / 16'd2) | (a & 16'h8000);
      4'd8: return (b & 16'h00FF) * 16'd256;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] model_a();
    return alu_src_a ? m_rf[m_ir[11:10]] : m_pc;
  endfunction

  function automatic logic [15:0] model_b();
    case (alu_src_b)
      2'd0:    return m_rf[m_ir[9:8]];
      2'd1:    return 16'd1;
      2'd2:    return {{8{m_ir[7]}}, m_ir[7:0]};
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [1:0] cmp_model(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa == sb) return 2'b00;
    if (sa < sb)  return 2'b01;
    return 2'b10;
  endfunction

  task automatic modelReset();
    m_pc = PC_INIT; m_ir = '0; m_mdr = '0; m_alu_out = '0; m_out = '0; m_out_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
  endtask

  // Effect of one clock edge on the non-memory architectural state.
  task automatic stepModel();
    logic [15:0] res, wd, npc;
    logic [1:0]  wa;
    res = alu_model(model_a(), model_b(), alu_op);
    case (mem_to_reg)
      2'd1:    wd = m_mdr;
      2'd2:    wd = m_pc + 16'd1;
      default: wd = m_alu_out;
    endcase
    case (reg_dst)
      2'd1:    wa = m_ir[7:6];
      2'd2:    wa = 2'd2;
      default: wa = m_ir[9:8];
    endcase
    case (pc_source)
      2'd0:    npc = res;
      2'd1:    npc = m_alu_out;
      2'd2:    npc = m_rf[m_ir[11:10]];
      default: npc = {m_pc[15:12], m_ir[11:0]};
    endcase
    m_out_valid = out_write;
    if (out_write) m_out = m_rf[m_ir[11:10]];
    if (pc_write)  m_pc = npc;
    if (reg_write) m_rf[wa] = wd;
    m_alu_out = res;
  endtask

  task automatic tick();
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic idleControls();
    reg_write = 0; pc_write = 0; out_write = 0; mem_start = 0; mem_ack = 0;
    mem_we = 0; iord = 0; mem_fetch = 0;
  endtask

  // One complete memory access; returns in the mem_done cycle.
  task automatic memAccess(input logic we, input logic sel, input logic fetch,
                           input logic [15:0] rdata, input int delay);
    logic [15:0] exp_addr, exp_wdata;
    exp_addr  = sel ? m_alu_out : m_pc;
    exp_wdata = m_rf[m_ir[9:8]];
    mem_start = 1; mem_we = we; iord = sel; mem_fetch = fetch; mem_ack = 0;
    tick();
    obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wr = mem_wr;
    pc_write = 0; reg_write = 0; out_write = 0;
    checkOutput("req_rise", mem_req, 1);
    checkOutput("req_busy", mem_busy, 1);
    checkOutput("req_addr", mem_addr, exp_addr);
    checkOutput("req_wdata", mem_wdata, exp_wdata);
    checkOutput("req_wr", mem_wr, we);
    for (int i = 0; i < delay; i++) begin
      mem_start = 1'($urandom); mem_we = 1'($urandom); iord = 1'($urandom);
      mem_fetch = 1'($urandom); mem_rdata = 16'($urandom);
      tick();
      checkOutput("req_hold", mem_req, 1);
      checkOutput("addr_stable", mem_addr, exp_addr);
      checkOutput("wdata_stable", mem_wdata, exp_wdata);
      checkOutput("wr_stable", mem_wr, we);
      checkOutput("no_early_done", mem_done, 0);
    end
    mem_start = 0; mem_ack = 1; mem_rdata = rdata;
    tick();
    mem_ack = 0; mem_rdata = 16'($urandom);
    if (!we) begin
      m_mdr = rdata;
      if (fetch) m_ir = rdata;
    end
    checkOutput("req_drop", mem_req, 0);
    checkOutput("done_pulse", mem_done, 1);
    checkOutput("ir_after_ack", ir_out, m_ir);
  endtask

  task automatic checkDoneEnds();
    checkOutput("done_single", mem_done, 0);
    checkOutput("idle_after_done", mem_busy, 0);
  endtask

  // Load a register through MDR: a read, then a write-back in the done cycle.
  task automatic writeReg(input logic [15:0] value, input logic [1:0] dst);
    memAccess(0, 0, 0, value, 0);
    reg_write = 1; reg_dst = dst; mem_to_reg = 2'd1;
    tick();
    reg_write = 0;
    checkDoneEnds();
  endtask

  task automatic checkRegs();
    checkOutput("out_valid", output_valid, m_out_valid);
    checkOutput("out_port", output_port, m_out);
    checkOutput("ir_hold", ir_out, m_ir);
  endtask

  // One randomized cycle: either a memory access or random datapath controls.
  task automatic applyStimulus();
    if ($urandom_range(0, 7) == 0) begin
      memAccess(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3));
      tick();
      checkDoneEnds();
    end else begin
      reg_write = 1'($urandom); reg_dst = 2'($urandom); mem_to_reg = 2'($urandom);
      alu_src_a = 1'($urandom); alu_src_b = 2'($urandom); alu_op = 4'($urandom);
      pc_source = 2'($urandom); pc_write = 1'($urandom); out_write = 1'($urandom);
      mem_start = 0; mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      #1;
      checkOutput("alu_compare", alu_compare, cmp_model(model_a(), model_b()));
      tick();
      checkRegs();
      checkOutput("ack_ignored", mem_busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] v;
    reset_n = 0;
    idleControls();
    reg_dst = 0; mem_to_reg = 0; alu_src_a = 0; alu_src_b = 0; alu_op = 0; pc_source = 0;
    mem_rdata = '0;
    modelReset();
    #2;
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_busy", mem_busy, 0);
    checkOutput("rst_done", mem_done, 0);
    checkOutput("rst_wr", mem_wr, 0);
    checkOutput("rst_ir", ir_out, 0);
    checkOutput("rst_out", output_port, 0);
    checkOutput("rst_outv", output_valid, 0);
    @(negedge clk);
    reset_n = 1;

    // Each RF entry reads zero after reset
    for (int r = 0; r < 4; r++) begin
      v = 16'(r) << 10;
      memAccess(0, 0, 1, v, 0);
      out_write = 1;
      tick();
      out_write = 0;
      checkRegs();
      checkOutput("rf_zero", output_port, 0);
    end

    // Fetch with a 3-cycle acknowledge delay
    memAccess(0, 0, 1, 16'h6A05, 3);
    checkOutput("fetch_addr", obs_addr, 16'h0010);
    checkOutput("fetch_ir", ir_out, 16'h6A05);
    tick();
    checkDoneEnds();

    // Store: RF[rt]=0x1234, ALUOut=0x0040
    memAccess(0, 0, 1, 16'h0640, 0);
    tick();
    writeReg(16'h1234, 2'd0);
    writeReg(16'h0040, 2'd1);
    alu_src_a = 1; alu_src_b = 2'd3; alu_op = 4'd0;
    tick();
    memAccess(1, 1, 0, 16'hBEEF, 2);
    checkOutput("store_addr", obs_addr, 16'h0040);
    checkOutput("store_wdata", obs_wdata, 16'h1234);
    checkOutput("store_wr", obs_wr, 1);
    reg_write = 1; reg_dst = 2'd1; mem_to_reg = 2'd1;
    tick();
    reg_write = 0; out_write = 1;
    tick();
    out_write = 0;
    checkRegs();
    checkOutput("mdr_kept_on_write", output_port, 16'h0040);

    // Back-to-back zero-wait accesses; start in the done cycle is ignored
    memAccess(0, 0, 0, 16'h1111, 0);
    mem_start = 1; mem_we = 0; iord = 0; mem_fetch = 0;
    tick();
    checkOutput("start_in_done_ignored", mem_req, 0);
    checkDoneEnds();
    memAccess(0, 0, 0, 16'h2222, 0);
    tick();
    checkDoneEnds();

    // ALU wrap: 0x7FFF + 1 = 0x8000
    writeReg(16'h7FFF, 2'd1);
    alu_src_a = 1; alu_src_b = 2'd1; alu_op = 4'd0;
    tick();
    reg_write = 1; reg_dst = 2'd1; mem_to_reg = 2'd0;
    tick();
    reg_write = 0; out_write = 1;
    tick();
    out_write = 0;
    checkRegs();
    checkOutput("alu_wrap", output_port, 16'h8000);

    // Signed compare: -3 vs 2
    writeReg(16'hFFFD, 2'd1);
    writeReg(16'h0002, 2'd0);
    alu_src_a = 1; alu_src_b = 2'd0;
    #1;
    checkOutput("cmp_neg_lt", alu_compare, 2'b01);

    // Jump target {PC[15:12], IR[11:0]}; pc_write alongside mem_start
    memAccess(0, 0, 1, 16'h0456, 1);
    tick();
    writeReg(16'hA123, 2'd1);
    pc_write = 1; pc_source = 2'd2;
    tick();
    pc_source = 2'd3;
    memAccess(0, 0, 0, 16'h3333, 1);
    checkOutput("addr_old_pc", obs_addr, 16'hA123);
    tick();
    memAccess(0, 0, 0, 16'h4444, 0);
    checkOutput("jump_pc", obs_addr, 16'hA456);
    tick();
    checkDoneEnds();

    // Reset while waiting in REQ
    mem_start = 1; mem_we = 0; iord = 0; mem_fetch = 1;
    tick();
    mem_start = 0;
    tick();
    checkOutput("pre_rst_req", mem_req, 1);
    #2;
    reset_n = 0;
    #1;
    checkOutput("rst_mid_req", mem_req, 0);
    checkOutput("rst_mid_busy", mem_busy, 0);
    checkOutput("rst_mid_ir", ir_out, 0);
    idleControls();
    modelReset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_done_after_rst", mem_done, 0);
      checkOutput("idle_after_rst", mem_busy, 0);
    end

    // Randomized operation against the model
    for (int n = 0; n < 400; n++) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
